// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
//   state_t    : FSM encoding shared by serial arithmetic controllers
//   borrow_out : per-bit borrow equation of a full subtractor
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Borrow leaves the bit when b exceeds a outright, or when the bits are
  // equal and a borrow came in from the bit below.
  function automatic logic borrow_out(input logic a, input logic b, input logic br);
    return (~a & b) | (~(a ^ b) & br);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: Diff = A - B - Bin, Bout = borrow to the next bit.
// Latency: combinational, zero cycles.
// Backpressure: none (pure logic).
//   A, B, Bin : minuend bit, subtrahend bit, borrow-in
//   Diff, Bout: difference bit, borrow-out
module full_subtractor
  import arith_pkg::*;
(
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic Diff,
  output logic Bout
);

  assign Diff = A ^ B ^ Bin;
  assign Bout = borrow_out(A, B, Bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial ripple-borrow subtractor: A - B - Bin, one bit per clock, LSB first.
// Latency: accept at edge k, done pulse in the cycle after edge k+WIDTH; one op per WIDTH+2 cycles.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped, not queued.
//   clk, rst_n       : clock, asynchronous active-low reset
//   start, A, B, Bin : request and operands, captured together in IDLE
//   busy, done       : busy while not IDLE; done is a one-cycle result strobe
//   Diff, Bout       : last result, held until the next operation completes
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_br;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;

  logic             w_d;
  logic             w_bout;
  logic [WIDTH-1:0] w_res_next;

  full_subtractor u_fs (
    .A    (r_a[0]),
    .B    (r_b[0]),
    .Bin  (r_br),
    .Diff (w_d),
    .Bout (w_bout)
  );

  // Result fills from the top so that after WIDTH shifts bit 0 sits at the LSB.
  assign w_res_next = {w_d, r_res[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_br    <= Bin;
            r_res   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_res <= w_res_next;
          r_br  <= w_bout;
          if (r_cnt == LAST_BIT) begin
            // Take the last bit straight from the step logic; r_res would be a cycle late.
            r_diff  <= w_res_next;
            r_bout  <= w_bout;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign Diff = r_diff;
  assign Bout = r_bout;

endmodule
